// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and default timing constants.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_t;

  localparam int DEF_PLL_RST_CYCLES      = 8;
  localparam int DEF_LOCK_STABLE_CYCLES  = 64;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 4096;
  localparam int DEF_STAGE_GAP           = 4;

  // Larger of two sizing values, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset; output resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make r_sync take the old r_meta, forming a real two-stage pipeline.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock controller: pulses the PLL reset, qualifies lock with a timeout,
// then releases three downstream reset domains in order. Runs on the reference clock.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int STAGE_GAP           = DEF_STAGE_GAP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic [2:0] rst_stage,
  output logic       ready,
  output logic [2:0] seq_state,
  output logic [7:0] relock_count
);

  // The phase counter times both the PLL reset pulse and the staged release.
  localparam int PHASE_W = $clog2(max_int(PLL_RST_CYCLES, 2 * STAGE_GAP) + 1);
  localparam int STB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int ATT_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [PHASE_W-1:0] PH_RST_LAST = PHASE_W'(PLL_RST_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PH_GAP      = PHASE_W'(STAGE_GAP);
  localparam logic [PHASE_W-1:0] PH_REL_LAST = PHASE_W'(2 * STAGE_GAP - 1);
  localparam logic [STB_W-1:0]   STB_LAST    = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [ATT_W-1:0]   ATT_LAST    = ATT_W'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic [STB_W-1:0]   r_stable;
  logic [STB_W-1:0]   w_stable_nxt;
  logic [ATT_W-1:0]   r_attempt;
  logic [ATT_W-1:0]   w_attempt_nxt;
  logic               r_pll_rst;
  logic               w_pll_rst_nxt;
  logic [2:0]         r_rst_stage;
  logic [2:0]         w_rst_stage_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic [7:0]         r_relock_count;
  logic [7:0]         w_relock_count_nxt;
  logic               w_lock_s;

  sync2 u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lock_s)
  );

  // State, counters and registered outputs; reset puts the PLL and all domains in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_PLL_RESET;
      r_phase        <= '0;
      r_stable       <= '0;
      r_attempt      <= '0;
      r_pll_rst      <= 1'b1;
      r_rst_stage    <= 3'b111;
      r_ready        <= 1'b0;
      r_relock_count <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase        <= w_phase_nxt;
      r_stable       <= w_stable_nxt;
      r_attempt      <= w_attempt_nxt;
      r_pll_rst      <= w_pll_rst_nxt;
      r_rst_stage    <= w_rst_stage_nxt;
      r_ready        <= w_ready_nxt;
      r_relock_count <= w_relock_count_nxt;
    end
  end

  // Next-state, counter and output decode; outputs are derived from the next state so they register with it.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
    w_state_nxt        = r_state;
    w_phase_nxt        = '0;
    w_stable_nxt       = '0;
    w_attempt_nxt      = '0;
    w_relock_count_nxt = r_relock_count;

    unique case (r_state)
      ST_PLL_RESET: if (r_phase == PH_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (r_attempt == ATT_LAST) w_state_nxt = ST_PLL_RESET;
        else if (w_lock_s)         w_state_nxt = ST_STABLE;
      end
      ST_STABLE: begin
        // Timeout outranks both lock loss and stable completion.
        if (r_attempt == ATT_LAST)     w_state_nxt = ST_PLL_RESET;
        else if (!w_lock_s)            w_state_nxt = ST_WAIT_LOCK;
        else if (r_stable == STB_LAST) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Lock loss outranks any pending stage release.
        if (!w_lock_s)                 w_state_nxt = ST_PLL_RESET;
        else if (r_phase == PH_REL_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN:   if (!w_lock_s || force_relock) w_state_nxt = ST_PLL_RESET;
      default:  w_state_nxt = ST_PLL_RESET;
    endcase

    // Phase restarts on every state change and only runs in the timed states.
    if ((w_state_nxt == r_state) && ((r_state == ST_PLL_RESET) || (r_state == ST_RELEASE)))
      w_phase_nxt = r_phase + 1'b1;

    // Stable run length; staying in STABLE implies lock_s was high this cycle.
    if ((r_state == ST_STABLE) && (w_state_nxt == ST_STABLE))
      w_stable_nxt = r_stable + 1'b1;

    // Attempt timer spans WAIT_LOCK and STABLE together; only PLL_RESET clears it.
    if (((r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE)) &&
        ((w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_STABLE)))
      w_attempt_nxt = r_attempt + 1'b1;

    if ((w_state_nxt == ST_PLL_RESET) && (r_state != ST_PLL_RESET) && (r_relock_count != 8'hFF))
      w_relock_count_nxt = r_relock_count + 1'b1;

    w_pll_rst_nxt = (w_state_nxt == ST_PLL_RESET);
    w_ready_nxt   = (w_state_nxt == ST_RUN);
    case (w_state_nxt)
      ST_RELEASE: w_rst_stage_nxt = (w_phase_nxt >= PH_GAP) ? 3'b100 : 3'b110;
      ST_RUN:     w_rst_stage_nxt = 3'b000;
      default:    w_rst_stage_nxt = 3'b111;
    endcase
  end

  assign pll_rst      = r_pll_rst;
  assign rst_stage    = r_rst_stage;
  assign ready        = r_ready;
  assign seq_state    = r_state;
  assign relock_count = r_relock_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic [2:0] rst_stage;
  logic       ready;
  logic [2:0] seq_state;
  logic [7:0] relock_count;

  int total = 0;
  int bad   = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .STAGE_GAP           (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .rst_stage    (rst_stage),
    .ready        (ready),
    .seq_state    (seq_state),
    .relock_count (relock_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset across an edge, release on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    tick(2);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL reset_stage got=%b exp=111", rst_stage); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", seq_state); end
    total++; if (relock_count !== 8'd0) begin bad++; $display("FAIL reset_relock got=%0d exp=0", relock_count); end
  endtask

  task automatic test_clean_lock();
    do_reset();
    tick(3);
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL clean_pll_rst_e3 got=%b exp=1", pll_rst); end
    tick(1);
    total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL clean_pll_rst_e4 got=%b exp=0", pll_rst); end
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL clean_wait_e4 got=%0d exp=1", seq_state); end
    pll_locked = 1'b1;
    tick(2);
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL clean_state_E1 got=%0d exp=1", seq_state); end
    tick(1);
    total++; if (seq_state !== 3'd2) begin bad++; $display("FAIL clean_state_E2 got=%0d exp=2", seq_state); end
    tick(7);
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL clean_stage_E9 got=%b exp=111", rst_stage); end
    tick(1);
    total++; if (rst_stage !== 3'b110) begin bad++; $display("FAIL clean_stage_E10 got=%b exp=110", rst_stage); end
    total++; if (seq_state !== 3'd3) begin bad++; $display("FAIL clean_state_E10 got=%0d exp=3", seq_state); end
    tick(1);
    total++; if (rst_stage !== 3'b110) begin bad++; $display("FAIL clean_stage_E11 got=%b exp=110", rst_stage); end
    tick(1);
    total++; if (rst_stage !== 3'b100) begin bad++; $display("FAIL clean_stage_E12 got=%b exp=100", rst_stage); end
    tick(1);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL clean_ready_E13 got=%b exp=0", ready); end
    tick(1);
    total++; if (rst_stage !== 3'b000) begin bad++; $display("FAIL clean_stage_E14 got=%b exp=000", rst_stage); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL clean_ready_E14 got=%b exp=1", ready); end
    total++; if (seq_state !== 3'd4) begin bad++; $display("FAIL clean_state_E14 got=%0d exp=4", seq_state); end
    total++; if (relock_count !== 8'd0) begin bad++; $display("FAIL clean_relock got=%0d exp=0", relock_count); end
  endtask

  task automatic test_no_lock();
    int rem;
    do_reset();
    tick(4);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL nolock_force_ignored got=%0d exp=1", seq_state); end
    total++; if (relock_count !== 8'd0) begin bad++; $display("FAIL nolock_force_relock got=%0d exp=0", relock_count); end
    rem = 31;
    for (int k = 1; k <= 3; k++) begin
      tick(rem - 1);
      total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL nolock_wait_%0d got=%0d exp=1", k, seq_state); end
      tick(1);
      total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL nolock_timeout_%0d got=%0d exp=0", k, seq_state); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL nolock_pll_rst_%0d got=%b exp=1", k, pll_rst); end
      total++; if (relock_count !== 8'(k)) begin bad++; $display("FAIL nolock_relock_%0d got=%0d exp=%0d", k, relock_count, k); end
      tick(3);
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL nolock_pulse_%0d got=%b exp=1", k, pll_rst); end
      tick(1);
      total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL nolock_pulse_end_%0d got=%b exp=0", k, pll_rst); end
      rem = 32;
    end
  endtask

  task automatic test_glitchy_lock();
    do_reset();
    tick(4);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    total++; if (seq_state !== 3'd2) begin bad++; $display("FAIL glitch_stable_E6 got=%0d exp=2", seq_state); end
    tick(1);
    total++; if (seq_state !== 3'd1) begin bad++; $display("FAIL glitch_wait_E7 got=%0d exp=1", seq_state); end
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL glitch_stage_E7 got=%b exp=111", rst_stage); end
    tick(1);
    total++; if (seq_state !== 3'd2) begin bad++; $display("FAIL glitch_stable_E8 got=%0d exp=2", seq_state); end
    tick(7);
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL glitch_stage_E15 got=%b exp=111", rst_stage); end
    tick(1);
    total++; if (rst_stage !== 3'b110) begin bad++; $display("FAIL glitch_stage_E16 got=%b exp=110", rst_stage); end
    // Repeating glitches never give 8 clean cycles, so the attempt timer must expire.
    do_reset();
    tick(4);
    for (int i = 0; i < 32; i++) begin
      pll_locked = (i % 6 != 5);
      tick(1);
      if (i == 30) begin
        total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL glitch_to_stage got=%b exp=111", rst_stage); end
        total++; if (relock_count !== 8'd0) begin bad++; $display("FAIL glitch_to_pre got=%0d exp=0", relock_count); end
      end
    end
    total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL glitch_timeout got=%0d exp=0", seq_state); end
    total++; if (relock_count !== 8'd1) begin bad++; $display("FAIL glitch_timeout_relock got=%0d exp=1", relock_count); end
  endtask

  task automatic bring_up();
    do_reset();
    tick(4);
    pll_locked = 1'b1;
    tick(15);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL bringup_ready got=%b exp=1", ready); end
  endtask

  task automatic test_loss_in_run();
    bring_up();
    pll_locked = 1'b0;
    tick(2);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL loss_run_F1 got=%b exp=1", ready); end
    tick(1);
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL loss_run_stage got=%b exp=111", rst_stage); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL loss_run_ready got=%b exp=0", ready); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL loss_run_pll_rst got=%b exp=1", pll_rst); end
    total++; if (relock_count !== 8'd1) begin bad++; $display("FAIL loss_run_relock got=%0d exp=1", relock_count); end
  endtask

  task automatic test_force_relock();
    bring_up();
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL force_state got=%0d exp=0", seq_state); end
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL force_stage got=%b exp=111", rst_stage); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL force_ready got=%b exp=0", ready); end
    total++; if (relock_count !== 8'd1) begin bad++; $display("FAIL force_relock got=%0d exp=1", relock_count); end
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    total++; if (relock_count !== 8'd1) begin bad++; $display("FAIL force_ignored got=%0d exp=1", relock_count); end
  endtask

  task automatic test_loss_in_release();
    do_reset();
    tick(4);
    pll_locked = 1'b1;
    tick(9);
    pll_locked = 1'b0;
    tick(2);
    total++; if (rst_stage !== 3'b110) begin bad++; $display("FAIL lossrel_stage_E10 got=%b exp=110", rst_stage); end
    tick(1);
    total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL lossrel_state got=%0d exp=0", seq_state); end
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL lossrel_stage_E11 got=%b exp=111", rst_stage); end
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL lossrel_pll_rst got=%b exp=1", pll_rst); end
    total++; if (relock_count !== 8'd1) begin bad++; $display("FAIL lossrel_relock got=%0d exp=1", relock_count); end
    tick(1);
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL lossrel_stage_E12 got=%b exp=111", rst_stage); end
  endtask

  task automatic test_async_reset();
    bring_up();
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    tick(13);
    total++; if (seq_state !== 3'd3) begin bad++; $display("FAIL async_pre_state got=%0d exp=3", seq_state); end
    total++; if (relock_count !== 8'd1) begin bad++; $display("FAIL async_pre_relock got=%0d exp=1", relock_count); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL async_pll_rst got=%b exp=1", pll_rst); end
    total++; if (rst_stage !== 3'b111) begin bad++; $display("FAIL async_stage got=%b exp=111", rst_stage); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL async_ready got=%b exp=0", ready); end
    total++; if (seq_state !== 3'd0) begin bad++; $display("FAIL async_state got=%0d exp=0", seq_state); end
    total++; if (relock_count !== 8'd0) begin bad++; $display("FAIL async_relock got=%0d exp=0", relock_count); end
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_no_lock();
    test_glitchy_lock();
    test_loss_in_run();
    test_force_relock();
    test_loss_in_release();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
